// File: rtl/oled_text_refresh_if.sv
// Host write port and downstream OLED command port of oled_text_refresh.
// master = host/driver side, slave = the refresh engine.
interface oled_text_refresh_if;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic       oled_ready;
  logic [8:0] oled_cmd;
  logic       oled_strobe;
  logic       oled_wait;
  logic       init_done;

  modport master (
    output wr_en, wr_addr, wr_data, oled_ready,
    input  oled_cmd, oled_strobe, oled_wait, init_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, oled_ready,
    output oled_cmd, oled_strobe, oled_wait, init_done
  );
endinterface

// File: rtl/oled_text_refresh.sv
// 2x16 character OLED refresher: init sequence, then redraws text buffer cells.
// Define OLED_DIRTY_TRACK_EN to redraw only changed cells; default redraws all cells forever.
//
// state | meaning
// INIT  | issue the five-command init sequence
// SCAN  | test one cell per cycle at ptr
// ADDR  | issue DDRAM address for cell ptr
// CHAR  | issue character code for cell ptr
// GUARD | one dead cycle after every strobe, oled_ready ignored
module oled_text_refresh #(
  parameter bit CMD_WAIT = 1'b1
) (
  input logic                clk_48mhz,
  input logic                reset,
  oled_text_refresh_if.slave bus
);
  typedef enum logic [2:0] {INIT, SCAN, ADDR, CHAR, GUARD} state_t;

  state_t     state_q, ret_q;
  logic [2:0] init_idx_q;
  logic [4:0] ptr_q;
  logic [8:0] cmd_q;
  logic       vld_q;
  logic       init_done_q;
  logic [7:0] buf_q [32];

  logic       strobe;
  logic       wr_hit;
  logic [7:0] cell_now;
  logic [8:0] init_cmd;
  logic       cell_dirty;

  always_comb begin
    case (init_idx_q)
      3'd0:    init_cmd = 9'h038;
      3'd1:    init_cmd = 9'h01F;
      3'd2:    init_cmd = 9'h00E;
      3'd3:    init_cmd = 9'h001;
      default: init_cmd = 9'h006;
    endcase
  end

  // Strobe is qualified by the live ready so no command ever leaves while the port is busy.
  assign strobe   = vld_q & bus.oled_ready & ~reset;
  assign wr_hit   = bus.wr_en & (bus.wr_addr == ptr_q);
  assign cell_now = wr_hit ? bus.wr_data : buf_q[ptr_q];

  assign bus.oled_cmd    = cmd_q;
  assign bus.oled_strobe = strobe;
  assign bus.oled_wait   = CMD_WAIT;
  assign bus.init_done   = init_done_q;

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
    end else if (bus.wr_en) begin
      buf_q[bus.wr_addr] <= bus.wr_data;
    end
  end

`ifdef OLED_DIRTY_TRACK_EN
  logic [31:0] dirty_q;

  assign cell_dirty = dirty_q[ptr_q];

  // Host set is applied after the CHAR clear so a write racing the strobe is redrawn later.
  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      dirty_q <= '1;
    end else begin
      if (state_q == CHAR && strobe) dirty_q[ptr_q] <= 1'b0;
      if (bus.wr_en) dirty_q[bus.wr_addr] <= 1'b1;
    end
  end
`else
  assign cell_dirty = 1'b1;
`endif

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_q     <= INIT;
      ret_q       <= INIT;
      init_idx_q  <= '0;
      ptr_q       <= '0;
      cmd_q       <= '0;
      vld_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (!vld_q) begin
            cmd_q <= init_cmd;
            vld_q <= 1'b1;
          end else if (strobe) begin
            vld_q   <= 1'b0;
            state_q <= GUARD;
            if (init_idx_q == 3'd4) begin
              ret_q       <= SCAN;
              init_done_q <= 1'b1;
            end else begin
              ret_q      <= INIT;
              init_idx_q <= init_idx_q + 3'd1;
            end
          end
        end
        SCAN: begin
          if (cell_dirty) begin
            cmd_q   <= {1'b0, 1'b1, ptr_q[4], 2'b00, ptr_q[3:0]};
            vld_q   <= 1'b1;
            state_q <= ADDR;
          end else begin
            ptr_q <= ptr_q + 5'd1;
          end
        end
        ADDR: begin
          if (strobe) begin
            vld_q   <= 1'b0;
            ret_q   <= CHAR;
            state_q <= GUARD;
          end
        end
        CHAR: begin
          // Track the buffer while waiting so the strobe carries the latest character.
          if (strobe) begin
            vld_q   <= 1'b0;
            ret_q   <= SCAN;
            state_q <= GUARD;
            ptr_q   <= ptr_q + 5'd1;
          end else begin
            cmd_q <= {1'b1, cell_now};
          end
        end
        GUARD: begin
          state_q <= ret_q;
          if (ret_q == CHAR) begin
            cmd_q <= {1'b1, cell_now};
            vld_q <= 1'b1;
          end
        end
        default: state_q <= INIT;
      endcase
    end
  end
endmodule

// File: doc/oled_text_refresh.md
OLED_TEXT_REFRESH -- requirements
Module: oled_text_refresh

Interface
REQ-001 SHALL have parameter CMD_WAIT, default 1, meaning the value driven on oled_wait with every command.
REQ-002 SHALL have port clk_48mhz, input, 1 bit: clock; all logic is on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port wr_en, input, 1 bit: host write strobe into the text buffer.
REQ-005 SHALL have port wr_addr, input, 5 bits: cell index; 0-15 is line 1, 16-31 is line 2.
REQ-006 SHALL have port wr_data, input, 8 bits: character code.
REQ-007 SHALL have port oled_ready, input, 1 bit: downstream command port idle.
REQ-008 SHALL have port oled_cmd, output, 9 bits: {rs, data[7:0]} to the downstream driver.
REQ-009 SHALL have port oled_strobe, output, 1 bit: one-cycle command pulse.
REQ-010 SHALL have port oled_wait, output, 1 bit: busy-poll request to the downstream driver, held at CMD_WAIT.
REQ-011 SHALL have port init_done, output, 1 bit: high once the init sequence has been issued.

Function
REQ-012 SHALL hold a 32x8 text buffer plus 32 dirty flags; wr_en writes wr_data at wr_addr in the same cycle, sets that cell's dirty flag, and is always accepted.
REQ-013 SHALL use the states INIT, SCAN, ADDR, CHAR and GUARD.
REQ-014 In INIT, SHALL issue in order 0x038, 0x01F, 0x00E, 0x001, 0x006, each with rs=0, then go to SCAN and set init_done.
REQ-015 SHALL assert oled_strobe for exactly one cycle, only in a cycle where oled_ready=1, with oled_cmd valid in that same cycle.
REQ-016 After every strobe, SHALL enter GUARD for one cycle and ignore oled_ready, then resume waiting for oled_ready=1.
REQ-017 In SCAN, SHALL test one cell per cycle at pointer ptr; ptr increments modulo 32 (31 wraps to 0) whenever the tested cell is clean.
REQ-018 On a dirty cell, SCAN SHALL go to ADDR and issue {0, 0x80 | (ptr[4] ? 0x40 : 0x00) | ptr[3:0]}.
REQ-019 After ADDR, CHAR SHALL issue {1, buffer[ptr]} sampled in the strobe cycle, clear dirty[ptr], increment ptr, and return to SCAN.
REQ-020 If wr_en hits cell ptr in the CHAR strobe cycle, the set SHALL win over the clear, so the dirty flag stays 1 and the cell is resent on a later pass.
REQ-021 Host writes during INIT SHALL be buffered and marked dirty, then drawn after init.
REQ-022 SHALL never have more than one command outstanding; oled_strobe=0 in every cycle with oled_ready=0.

Reset
REQ-023 On reset=1, SHALL set state=INIT, the init index to 0, ptr=0, oled_strobe=0, oled_cmd=0, init_done=0, every buffer cell to 0x20, and every dirty flag to 1.
REQ-024 oled_wait SHALL equal CMD_WAIT during and after reset.
REQ-025 Reset asserted mid-command SHALL abort immediately; the sequence restarts from the first INIT command once oled_ready=1.
REQ-026 Reset SHALL take priority over wr_en in the same cycle.

Configuration
REQ-027 The feature macro SHALL be OLED_DIRTY_TRACK_EN.
REQ-028 With OLED_DIRTY_TRACK_EN defined, SHALL redraw only dirty cells as in REQ-017 to REQ-020.
REQ-029 Without OLED_DIRTY_TRACK_EN, SHALL have no dirty flags and treat every cell as dirty, so all 32 cells are redrawn continuously in order 0..31, wrapping.
REQ-030 Without OLED_DIRTY_TRACK_EN, REQ-012 SHALL apply to buffer data only.

Verification
REQ-031 Bench SHALL hold oled_ready=1 except 1 cycle after each strobe, release reset, and check the first 5 strobes carry 0x038, 0x01F, 0x00E, 0x001, 0x006, with init_done rising after the 5th.
REQ-032 Bench SHALL, after reset, check 32 pairs: cell 0 gives 0x080 then 0x120; cell 16 gives 0x0C0 then 0x120; cell 31 gives 0x0CF then 0x120; then no strobes with dirty tracking on.
REQ-033 Bench SHALL, once idle, write addr=5 data=0x41, and check exactly 0x085 then 0x141 follow with nothing after.
REQ-034 Bench SHALL write addr=7 data=0x42 in the CHAR strobe cycle for cell 7, and check a second 0x087/0x142 pair is issued.
REQ-035 Bench SHALL hold oled_ready=0 for 100 cycles after an ADDR strobe and check no strobe occurs; on ready=1, exactly one CHAR strobe occurs.
REQ-036 Bench SHALL assert reset for 1 cycle between an ADDR and a CHAR strobe, and check the next strobe is 0x038 and all cells are redrawn as 0x20.
